// File: rtl/wb_ctrl_pkg.sv
// Shared constants and the write-source tag for the write-back controller.
package wb_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    // Which result path produced the registered regfile write.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

endpackage

// File: rtl/wb_ctrl_sync_fifo.sv
// Small synchronous FIFO. Its pointers carry one extra wrap bit, which keeps
// full and empty distinguishable. A push into a full FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Advance the pointers on accepted push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The storage array has no reset. Empty pointers make stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU and buffered load results onto the
// single regfile write port and keeps a pending-load busy scoreboard.
module wb_ctrl #(
    parameter int XLEN         = wb_ctrl_pkg::XLEN,
    parameter int LD_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [XLEN-1:0] ld_data_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [4:0]      rs2_idx_i,
    input  logic [4:0]      dec_rd_i,
    output logic            stall_o,
    output logic            wen_o,
    output logic [4:0]      rd_idx_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [31:0]     busy_o
);

    import wb_ctrl_pkg::*;

    localparam int FW = REG_IDX_W + XLEN;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]        fifo_head;
    logic [REG_IDX_W-1:0] head_rd;
    logic [XLEN-1:0]      head_data;
    logic                 force_ld, alu_grant;

    logic [SW-1:0]        starve_q, starve_d;
    logic                 wen_q, wen_d;
    logic [REG_IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]      rd_data_q, rd_data_d;
    src_e                 src_q, src_d;
    logic [31:0]          busy_q, busy_d;

    sync_fifo #(.WIDTH(FW), .DEPTH(LD_DEPTH)) u_ld_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({ld_rd_i, ld_data_i}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_rd   = fifo_head[FW-1:XLEN];
    assign head_data = fifo_head[XLEN-1:0];

    // Arbitration: ALU wins unless queued loads have waited STARVE_LIMIT grants.
    always_comb begin
        force_ld  = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
        alu_grant = alu_valid_i && !force_ld;
        fifo_pop  = !alu_grant && !fifo_empty;
        fifo_push = ld_valid_i && !fifo_full;
    end

    assign alu_ready_o = !force_ld;
    assign ld_ready_o  = !fifo_full;

    // Starvation counter: count ALU grants while loads wait, saturating.
    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty)
            starve_d = '0;
        else if (alu_grant && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);
    end

    // Next regfile write. An x0 result is consumed but leaves index and data untouched.
    always_comb begin
        wen_d     = 1'b0;
        rd_idx_d  = rd_idx_q;
        rd_data_d = rd_data_q;
        src_d     = src_q;
        if (alu_grant) begin
            src_d = SRC_ALU;
            if (alu_rd_i != '0) begin
                wen_d     = 1'b1;
                rd_idx_d  = alu_rd_i;
                rd_data_d = alu_data_i;
            end
        end else if (fifo_pop) begin
            src_d = SRC_LD;
            if (head_rd != '0) begin
                wen_d     = 1'b1;
                rd_idx_d  = head_rd;
                rd_data_d = head_data;
            end
        end
    end

    // Scoreboard. A busy bit clears on the edge where the regfile captures the load,
    // and a set on the same edge overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (wen_q && (src_q == SRC_LD)) busy_d[rd_idx_q] = 1'b0;
        if (issue_valid_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign stall_o = busy_q[rs1_idx_i] | busy_q[rs2_idx_i] | busy_q[dec_rd_i];

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q  <= '0;
            wen_q     <= 1'b0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
            src_q     <= SRC_ALU;
            busy_q    <= '0;
        end else begin
            starve_q  <= starve_d;
            wen_q     <= wen_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
            src_q     <= src_d;
            busy_q    <= busy_d;
        end
    end

    assign wen_o     = wen_q;
    assign rd_idx_o  = rd_idx_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed and random bench for wb_ctrl, checked against a queue-based reference model.
module tb_wb_ctrl;

    localparam int XLEN         = 32;
    localparam int LD_DEPTH     = 4;
    localparam int STARVE_LIMIT = 3;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i;
    logic            alu_valid_i;
    logic            alu_ready_o;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            ld_valid_i;
    logic            ld_ready_o;
    logic [4:0]      ld_rd_i;
    logic [XLEN-1:0] ld_data_i;
    logic [4:0]      rs1_idx_i, rs2_idx_i, dec_rd_i;
    logic            stall_o;
    logic            wen_o;
    logic [4:0]      rd_idx_o;
    logic [XLEN-1:0] rd_data_o;
    logic [31:0]     busy_o;

    wb_ctrl #(.XLEN(XLEN), .LD_DEPTH(LD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i), .dec_rd_i(dec_rd_i),
        .stall_o(stall_o), .wen_o(wen_o), .rd_idx_o(rd_idx_o),
        .rd_data_o(rd_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: the load FIFO is a queue, and the registered outputs are plain variables.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ld_t;

    ld_t             mq[$];
    int              m_starve;
    logic [31:0]     m_busy;
    logic            m_wen;
    logic            m_src_ld;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    bit              m_pushed;

    int checks = 0;
    int errors = 0;
    int alu_block_cnt;
    int ld_refuse_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_busy   = '0;
        m_wen    = 1'b0;
        m_src_ld = 1'b0;
        m_rd     = '0;
        m_data   = '0;
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_rd_i = 0;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        ld_valid_i = 0; ld_rd_i = 0; ld_data_i = 0;
    endtask

    // Runs one clock cycle. The inputs are already driven. The step checks the combinational
    // outputs, advances the model, then checks the registered outputs just after the edge.
    task automatic step();
        int          sz;
        bit          full, frc, alu_g, popping;
        ld_t         e;
        logic [31:0] nb;
        #1;
        sz   = mq.size();
        full = (sz == LD_DEPTH);
        frc  = (sz > 0) && (m_starve == STARVE_LIMIT);
        check("ld_ready", ld_ready_o, !full);
        check("alu_ready", alu_ready_o, !frc);
        check("stall", stall_o, m_busy[rs1_idx_i] | m_busy[rs2_idx_i] | m_busy[dec_rd_i]);
        if (alu_valid_i && alu_ready_o === 1'b0) alu_block_cnt++;
        if (ld_valid_i && ld_ready_o === 1'b0) ld_refuse_cnt++;

        alu_g   = alu_valid_i && !frc;
        popping = !alu_g && (sz > 0);

        nb = m_busy;
        if (m_wen && m_src_ld) nb[m_rd] = 1'b0;
        if (issue_valid_i && issue_rd_i != 0) nb[issue_rd_i] = 1'b1;

        m_wen = 1'b0;
        if (alu_g) begin
            m_src_ld = 1'b0;
            if (alu_rd_i != 0) begin m_wen = 1'b1; m_rd = alu_rd_i; m_data = alu_data_i; end
        end else if (popping) begin
            e = mq.pop_front();
            m_src_ld = 1'b1;
            if (e.rd != 0) begin m_wen = 1'b1; m_rd = e.rd; m_data = e.data; end
        end

        if (popping || sz == 0) m_starve = 0;
        else if (alu_g && m_starve < STARVE_LIMIT) m_starve++;

        m_pushed = ld_valid_i && !full;
        if (m_pushed) mq.push_back('{rd: ld_rd_i, data: ld_data_i});
        m_busy = nb;

        @(posedge clk_i);
        #1;
        check("wen", wen_o, m_wen);
        check("rd_idx", rd_idx_o, m_rd);
        check("rd_data", rd_data_o, m_data);
        check("busy", busy_o, m_busy);
    endtask

    initial begin
        int k;
        int r;
        reset_i = 1'b1;
        idle();
        rs1_idx_i = 0; rs2_idx_i = 0; dec_rd_i = 0;
        model_reset();
        #7;
        check("rst_wen", wen_o, 1'b0);
        check("rst_rd_idx", rd_idx_o, 5'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_busy", busy_o, 32'd0);
        check("rst_ld_ready", ld_ready_o, 1'b1);
        check("rst_alu_ready", alu_ready_o, 1'b1);
        #5 reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // A single ALU write
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h1337;
        step();
        check("alu_wen", wen_o, 1'b1);
        check("alu_data", rd_data_o, 32'h1337);
        idle();
        step();
        check("alu_wen_drop", wen_o, 1'b0);

        // x0 writes from both sources are consumed silently
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'hDEAD;
        step();
        idle();
        ld_valid_i = 1; ld_rd_i = 0; ld_data_i = 32'hBEEF;
        step();
        idle();
        step();
        check("x0_data_kept", rd_data_o, 32'h1337);
        step();
        check("x0_busy", busy_o, 32'd0);

        // Scoreboard set, stall, load write-back and clear
        issue_valid_i = 1; issue_rd_i = 5;
        step();
        idle();
        check("busy_set", busy_o, 32'h20);
        rs1_idx_i = 5;
        ld_valid_i = 1; ld_rd_i = 5; ld_data_i = 32'hCAFE;
        step();
        check("stall_busy", stall_o, 1'b1);
        idle();
        step();
        check("ld_wen", wen_o, 1'b1);
        check("ld_data", rd_data_o, 32'hCAFE);
        step();
        check("busy_clr", busy_o[5], 1'b0);
        check("stall_clr", stall_o, 1'b0);
        rs1_idx_i = 0;

        // Starvation limit: one queued load behind a continuous ALU stream
        alu_block_cnt = 0;
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h100;
        ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 32'h7777;
        step();
        ld_valid_i = 0;
        for (int i = 0; i < 6; i++) begin
            alu_rd_i = 5'(10 + i); alu_data_i = 32'h200 + 32'(i);
            step();
        end
        check("starve_blocks", alu_block_cnt, 1);
        idle();
        step();

        // FIFO full: the fifth load waits for a pop, and all loads drain in order
        ld_refuse_cnt = 0;
        alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h22;
        k = 0;
        for (int i = 0; i < 20 && k < 5; i++) begin
            ld_valid_i = 1; ld_rd_i = 5'(16 + k); ld_data_i = 32'h5000 + 32'(k);
            step();
            if (m_pushed) k++;
        end
        check("fifo_accepted", k, 5);
        check("fifo_refused", ld_refuse_cnt, 1);
        idle();
        for (int i = 0; i < 8; i++) step();

        // Asynchronous reset while two loads are queued
        issue_valid_i = 1; issue_rd_i = 2;
        step();
        issue_rd_i = 3;
        step();
        issue_valid_i = 0;
        alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h99;
        ld_valid_i = 1; ld_rd_i = 2; ld_data_i = 32'hA2;
        step();
        ld_rd_i = 3; ld_data_i = 32'hA3;
        step();
        check("pre_rst_busy", busy_o, 32'h0C);
        idle();
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst_wen", wen_o, 1'b0);
        check("mid_rst_busy", busy_o, 32'd0);
        check("mid_rst_ld_ready", ld_ready_o, 1'b1);
        model_reset();
        #2 reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) step();

        // Random traffic that respects the issue protocol
        for (int i = 0; i < 400; i++) begin
            alu_valid_i = 1'($urandom_range(0, 1));
            alu_rd_i    = 5'($urandom_range(0, 31));
            alu_data_i  = $urandom;
            ld_valid_i  = ($urandom_range(0, 2) == 0);
            ld_rd_i     = 5'($urandom_range(0, 31));
            ld_data_i   = $urandom;
            rs1_idx_i   = 5'($urandom_range(0, 31));
            rs2_idx_i   = 5'($urandom_range(0, 31));
            dec_rd_i    = 5'($urandom_range(0, 31));
            r = $urandom_range(1, 31);
            issue_valid_i = ($urandom_range(0, 3) == 0) && !m_busy[r];
            issue_rd_i    = 5'(r);
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
